mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data) in front of one shared memory port.
// Data wins by default; a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [2:0] starve_cnt;
    logic       if_live, dm_live;
    logic       grant_if, grant_dm;
    logic       done_if, done_dm;

    // A requester whose completion pulse is high this cycle is finishing, not asking again.
    assign if_live   = if_req & ~if_valid;
    assign dm_live   = dm_req & ~dm_valid;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;
    assign done_if   = (state == FETCH) && mem_ack;
    assign done_dm   = (state == DATA) && mem_ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_if) begin
                    state_nxt = FETCH;
                end else if (grant_dm) begin
                    state_nxt = DATA;
                end
            end
            FETCH, DATA: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if (if_live && (starve_cnt == STARVE_LIM)) begin
                grant_if = 1'b1;
            end else if (dm_live) begin
                grant_dm = 1'b1;
            end else if (if_live) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_valid <= done_if;
            dm_valid <= done_dm;
            if (done_if) begin
                if_rdata <= mem_rdata;
            end
            if (done_dm && !mem_we) begin
                dm_rdata <= mem_rdata;
            end

            if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (done_if || done_dm) begin
                mem_req <= 1'b0;
            end

            if (grant_if) begin
                starve_cnt <= '0;
            end else if (grant_dm && if_req && (starve_cnt < STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a reactive memory responder with programmable ack delay,
// per-requester scoreboards of expected read data, a vector table and corner-case sequences.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned delay;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_valid, dm_valid;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, resp_ack, man_ack, auto_ack;
    logic        stall_if, stall_mem;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned ack_delay = 0;
    int unsigned wait_cnt;
    logic        in_txn;
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata;
    logic [31:0] model_dm = '0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    bus_t        bus_log[$];
    vec_t        vecs[8];

    assign mem_ack = auto_ack ? resp_ack : man_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h2008_0005;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input string detail);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic push_dm(input logic we, input logic [31:0] addr);
        logic [31:0] e;
        e = we ? model_dm : rd_fn(addr);
        model_dm = e;
        dm_q.push_back(e);
    endtask

    task automatic wait_valid(input logic fetch, output int unsigned n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n++;
            if (fetch ? if_valid : dm_valid) return;
        end
        report_fail(fetch ? "if_valid_timeout" : "dm_valid_timeout", "no pulse within 64 cycles");
    endtask

    task automatic run_txn(input vec_t v);
        int unsigned n;
        bus_t b;
        ack_delay = v.delay;
        bus_log.delete();
        @(negedge clk);
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
            if_q.push_back(v.exp);
        end else begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
            dm_q.push_back(v.exp);
            model_dm = v.exp;
        end
        wait_valid(v.fetch, n);
        if_req = 1'b0;
        dm_req = 1'b0;
        check("latency", n, v.delay + 2);
        if (bus_log.size() == 0) begin
            report_fail("bus_log", "no memory transaction seen, required one");
        end else begin
            b = bus_log.pop_front();
            check("bus_addr", b.addr, v.addr);
            check("bus_we", 32'(b.we), v.fetch ? 32'd0 : 32'(v.we));
            if (!v.fetch && v.we) check("bus_wdata", b.wdata, v.wdata);
        end
    endtask

    // Memory responder and completion monitor share one process so pops precede new grants.
    initial begin
        resp_ack = 1'b0; mem_rdata = '0; in_txn = 1'b0; wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (if_valid && dm_valid) report_fail("dual_valid", "both valids high, required at most one");
            if (if_valid) begin
                if (if_q.size() == 0) report_fail("spurious_if_valid", "pulse seen, required none");
                else check("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_valid) begin
                if (dm_q.size() == 0) report_fail("spurious_dm_valid", "pulse seen, required none");
                else check("dm_rdata", dm_rdata, dm_q.pop_front());
            end
            if (resp_ack) begin
                resp_ack = 1'b0;
            end else if (auto_ack && mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1; wait_cnt = 0;
                    hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
                end else begin
                    check("mem_addr_hold", mem_addr, hold_addr);
                    check("mem_wdata_hold", mem_wdata, hold_wdata);
                    check("mem_we_hold", 32'(mem_we), 32'(hold_we));
                end
                if (wait_cnt >= ack_delay) begin
                    resp_ack = 1'b1;
                    mem_rdata = rd_fn(mem_addr);
                    bus_log.push_back('{mem_we, mem_addr, mem_wdata});
                    in_txn = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic [31:0] seq_exp[6];

        vecs[0] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0,         1, rd_fn(32'h1000_0004)};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         2, rd_fn(32'h0000_0100)};
        vecs[3] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0,         3, rd_fn(32'h1000_0008)};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 1, rd_fn(32'h0000_0100)};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         0, rd_fn(32'hFFFF_FFFC)};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         4, rd_fn(32'hFFFF_FFF0)};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0108, 32'hFFFF_FFFF, 0, rd_fn(32'hFFFF_FFFC)};

        reset = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_valids", {30'b0, if_valid, dm_valid}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_starve", 32'(dut.starve_cnt), 0);
        reset = 1'b1;

        // Minimum-latency fetch with ack tied high.
        ack_delay = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0; if_q.push_back(32'h2008_0005);
        #1 check("c0_stall_if", 32'(stall_if), 1);
        check("c0_mem_req", 32'(mem_req), 0);
        @(negedge clk);
        check("c1_mem_req", 32'(mem_req), 1);
        check("c1_mem_addr", mem_addr, 32'h0);
        check("c1_stall_if", 32'(stall_if), 1);
        @(negedge clk);
        check("c2_if_valid", 32'(if_valid), 1);
        check("c2_if_rdata", if_rdata, 32'h2008_0005);
        check("c2_stall_if", 32'(stall_if), 0);
        if_req = 1'b0;
        @(negedge clk);
        check("c3_if_valid", 32'(if_valid), 0);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Simultaneous requests: data first, fetch granted during the dm_valid cycle.
        @(negedge clk);
        ack_delay = 0; bus_log.delete();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hAB; push_dm(1'b1, 32'h10);
        if_req = 1'b1; if_addr = 32'h1000_0040; if_q.push_back(rd_fn(32'h1000_0040));
        @(negedge clk);
        check("both_c1_mem_we", 32'(mem_we), 1);
        check("both_c1_mem_addr", mem_addr, 32'h10);
        check("both_c1_mem_wdata", mem_wdata, 32'hAB);
        @(negedge clk);
        check("both_c2_dm_valid", 32'(dm_valid), 1);
        check("both_c2_mem_req", 32'(mem_req), 0);
        dm_req = 1'b0;
        @(negedge clk);
        check("both_c3_mem_req", 32'(mem_req), 1);
        check("both_c3_mem_we", 32'(mem_we), 0);
        check("both_c3_mem_addr", mem_addr, 32'h1000_0040);
        @(negedge clk);
        check("both_c4_if_valid", 32'(if_valid), 1);
        if_req = 1'b0;
        @(negedge clk);

        // Starvation: the fetcher drops out during each dm_valid cycle so data keeps winning.
        bus_log.delete();
        check("starve_start", 32'(dut.starve_cnt), 0);
        if_req = 1'b1; if_addr = 32'h1000_0080; if_q.push_back(rd_fn(32'h1000_0080));
        for (int k = 1; k <= 4; k++) begin
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200 + 32'(4 * k); push_dm(1'b0, dm_addr);
            seq_exp[k - 1] = dm_addr;
            if (k > 1) begin
                @(negedge clk);
                if_req = 1'b1;
            end
            wait_valid(1'b0, n);
            check("starve_cnt", 32'(dut.starve_cnt), 32'(k));
            if_req = 1'b0;
        end
        dm_addr = 32'h214; push_dm(1'b0, 32'h214);
        seq_exp[4] = 32'h1000_0080; seq_exp[5] = 32'h214;
        @(negedge clk);
        if_req = 1'b1;
        @(negedge clk);
        check("starve_fetch_addr", mem_addr, 32'h1000_0080);
        check("starve_fetch_we", 32'(mem_we), 0);
        check("starve_cleared", 32'(dut.starve_cnt), 0);
        wait_valid(1'b1, n);
        if_req = 1'b0;
        wait_valid(1'b0, n);
        dm_req = 1'b0;
        check("starve_grants", 32'(bus_log.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (bus_log.size() > 0) check("starve_order", bus_log.pop_front().addr, seq_exp[i]);
        end

        // Delayed ack: bus held stable, stall_mem high, single pulse.
        @(negedge clk);
        ack_delay = 5;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; push_dm(1'b0, 32'h44);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("wait_mem_req", 32'(mem_req), 1);
            check("wait_mem_addr", mem_addr, 32'h44);
            check("wait_stall_mem", 32'(stall_mem), 1);
            check("wait_dm_valid", 32'(dm_valid), 0);
        end
        @(negedge clk);
        check("wait_done_valid", 32'(dm_valid), 1);
        dm_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("wait_single_pulse", 32'(dm_valid), 0);
        end

        // Requester keeps dm_req high through its own valid pulse.
        ack_delay = 0; bus_log.delete();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h58; push_dm(1'b0, 32'h58);
        wait_valid(1'b0, n);
        @(negedge clk);
        check("nodup_mem_req", 32'(mem_req), 0);
        dm_req = 1'b0;
        @(negedge clk);
        check("nodup_mem_req2", 32'(mem_req), 0);
        check("nodup_grants", 32'(bus_log.size()), 1);

        // Reset in DATA, then a late ack must be ignored.
        auto_ack = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'h55;
        @(negedge clk);
        check("rstx_mem_req", 32'(mem_req), 1);
        reset = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b1; model_dm = '0;
        man_ack = 1'b1;
        check("rstx_mem_req0", 32'(mem_req), 0);
        check("rstx_mem_addr0", mem_addr, 0);
        check("rstx_mem_wdata0", mem_wdata, 0);
        check("rstx_mem_we0", 32'(mem_we), 0);
        @(negedge clk);
        man_ack = 1'b0;
        check("rstx_dm_valid", 32'(dm_valid), 0);
        check("rstx_dm_rdata", dm_rdata, 0);
        check("rstx_if_rdata", if_rdata, 0);
        check("rstx_mem_req1", 32'(mem_req), 0);
        @(negedge clk);
        check("rstx_dm_valid2", 32'(dm_valid), 0);
        auto_ack = 1'b1;
        run_txn('{1'b1, 1'b0, 32'h1000_00C0, 32'h0, 0, rd_fn(32'h1000_00C0)});

        repeat (3) @(negedge clk);
        check("if_q_drained", 32'(if_q.size()), 0);
        check("dm_q_drained", 32'(dm_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
